// File: rtl/lfsr_sched_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the LFSR scheduler.
package lfsr_sched_pkg;

  typedef enum logic [1:0] {NOSEED, LOAD, WARMUP, RUN} state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_REQ = 4;
  localparam int MAX_REQ     = 8;
  localparam int PTR_W       = 3;

  // Unused upper request bits are zero, so wrapping modulo MAX_REQ gives the same
  // order as wrapping modulo the real requester count.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr);
    logic [MAX_REQ-1:0] pick;
    logic [PTR_W-1:0]   idx;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = ptr + PTR_W'(i);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/lfsr_rand_sched_if.sv
// Seed, LFSR-core and requester signals of the scheduler; slave = scheduler side.
interface lfsr_rand_sched_if import lfsr_sched_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_REQ = DEF_NUM_REQ
);
  logic                seed_valid;
  logic [DATA_W-1:0]   seed_data;
  logic                seed_ready;
  logic                seed_err;
  logic                lfsr_load;
  logic [DATA_W-1:0]   lfsr_seed;
  logic                lfsr_step;
  logic [DATA_W-1:0]   lfsr_q;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  gnt;
  logic [DATA_W-1:0]   rand_data;
  logic                rand_ready;

  modport master (
    output seed_valid, seed_data, lfsr_q, req,
    input  seed_ready, seed_err, lfsr_load, lfsr_seed, lfsr_step, gnt, rand_data, rand_ready
  );

  modport slave (
    input  seed_valid, seed_data, lfsr_q, req,
    output seed_ready, seed_err, lfsr_load, lfsr_seed, lfsr_step, gnt, rand_data, rand_ready
  );
endinterface

// File: rtl/lfsr_rr_arbiter.sv
// Round-robin pick over the requesters plus the rotating priority pointer.
module lfsr_rr_arbiter import lfsr_sched_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt_next
);
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [MAX_REQ-1:0] w_req_ext;
  logic [MAX_REQ-1:0] w_pick;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W-1:0]   w_ptr_nxt;

  always_comb begin
    w_req_ext              = '0;
    w_req_ext[NUM_REQ-1:0] = req;
  end

  assign w_pick   = rr_pick(w_req_ext, r_rr_ptr);
  assign gnt_next = w_pick[NUM_REQ-1:0];

  // The winner gets lowest priority next time.
  always_comb begin
    w_idx = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (w_pick[k]) w_idx = PTR_W'(k);
    end
    w_ptr_nxt = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + PTR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset)           r_rr_ptr <= '0;
    else if (en && |req) r_rr_ptr <= w_ptr_nxt;
  end
endmodule

// File: rtl/lfsr_rand_sched.sv
// Seed load / warm-up sequencer and round-robin distributor of LFSR words.
// Optional grant/stall counters are built when LFSR_SCHED_STATS_EN is defined.
module lfsr_rand_sched import lfsr_sched_pkg::*; #(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int WARMUP_STEPS = 16
) (
  input  logic clock,
  input  logic reset,
  lfsr_rand_sched_if.slave bus
`ifdef LFSR_SCHED_STATS_EN
  ,
  output logic [31:0] grant_cnt,
  output logic [31:0] stall_cnt
`endif
);
  state_t             r_state, w_state_nxt;
  logic [7:0]         r_warm_cnt;
  logic               r_seed_err;
  logic [DATA_W-1:0]  r_lfsr_seed;
  logic [DATA_W-1:0]  r_rand_data;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] w_gnt_next;
  logic               w_seed_open, w_seed_take, w_seed_zero, w_seed_load;
  logic               w_lfsr_load, w_lfsr_step, w_rand_ready, w_arb_en, w_grant;

  assign w_seed_open = (r_state == NOSEED) || (r_state == RUN);
  assign w_seed_take = bus.seed_valid && w_seed_open;
  assign w_seed_zero = w_seed_take && (bus.seed_data == '0);
  assign w_seed_load = w_seed_take && (bus.seed_data != '0);
  assign w_grant     = w_arb_en && (|bus.req);

  always_comb begin
    w_state_nxt  = r_state;
    w_lfsr_load  = 1'b0;
    w_lfsr_step  = 1'b0;
    w_rand_ready = 1'b0;
    w_arb_en     = 1'b0;
    case (r_state)
      NOSEED: if (w_seed_load) w_state_nxt = LOAD;
      LOAD: begin
        w_lfsr_load = 1'b1;
        w_state_nxt = WARMUP;
      end
      WARMUP: begin
        w_lfsr_step = 1'b1;
        if (r_warm_cnt <= 8'd1) w_state_nxt = RUN;
      end
      RUN: begin
        w_rand_ready = 1'b1;
        // A new seed pre-empts this cycle's grant so no word from the old stream leaks out.
        if (w_seed_load) begin
          w_state_nxt = LOAD;
        end else begin
          w_arb_en    = 1'b1;
          w_lfsr_step = |bus.req;
        end
      end
      default: w_state_nxt = NOSEED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= NOSEED;
    else       r_state <= w_state_nxt;
  end

  lfsr_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock    (clock),
    .reset    (reset),
    .req      (bus.req),
    .en       (w_arb_en),
    .gnt_next (w_gnt_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_seed_err  <= 1'b0;
      r_lfsr_seed <= '0;
      r_warm_cnt  <= '0;
      r_gnt       <= '0;
      r_rand_data <= '0;
    end else begin
      r_seed_err <= w_seed_zero;
      if (w_seed_load) r_lfsr_seed <= bus.seed_data;
      if (r_state == LOAD)        r_warm_cnt <= 8'(WARMUP_STEPS);
      else if (r_state == WARMUP) r_warm_cnt <= r_warm_cnt - 8'd1;
      r_gnt <= w_grant ? w_gnt_next : '0;
      if (w_grant) r_rand_data <= bus.lfsr_q;
    end
  end

  assign bus.seed_ready = w_seed_open;
  assign bus.seed_err   = r_seed_err;
  assign bus.lfsr_load  = w_lfsr_load;
  assign bus.lfsr_seed  = r_lfsr_seed;
  assign bus.lfsr_step  = w_lfsr_step;
  assign bus.gnt        = r_gnt;
  assign bus.rand_data  = r_rand_data;
  assign bus.rand_ready = w_rand_ready;

`ifdef LFSR_SCHED_STATS_EN
  logic [31:0]        r_grant_cnt, r_stall_cnt;
  logic [NUM_REQ-1:0] w_unserved;

  assign w_unserved = bus.req & ~(w_grant ? w_gnt_next : '0);

  always_ff @(posedge clock) begin
    if (reset || w_seed_load) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_grant && (r_grant_cnt != '1)) r_grant_cnt <= r_grant_cnt + 32'd1;
      if ((r_state == RUN) && (|w_unserved) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign grant_cnt = r_grant_cnt;
  assign stall_cnt = r_stall_cnt;
`endif
endmodule
